// File: rtl/mem_read_streamer.sv
// mem_read_streamer
//   Walks a {base, len} burst of sequential addresses through a single-read-port
//   memory (ren/raddr in, rdata one cycle later) and returns the data as a
//   valid/ready stream through a small output FIFO. A read is only issued when a
//   FIFO slot is guaranteed for its data, so the FIFO can never overflow.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   cmd_valid/cmd_ready     burst command handshake (accepted only when idle)
//   cmd_base, cmd_len       first address, beats minus one
//   mem_ren, mem_raddr      read request to memory
//   mem_rdata               read data, valid the cycle after mem_ren
//   out_valid/out_ready     output stream handshake
//   out_data, out_last      FIFO head data, final-beat-of-burst flag
//   busy                    burst in progress or FIFO non-empty
//
// Configuration
//   MEM_STREAM_STATS_EN     when defined, adds stall_cnt[15:0] (output stall
//                           cycles) and issue_stall[15:0] (credit-blocked issue
//                           cycles), both saturating, cleared on reset and on
//                           each command handshake.
module mem_read_streamer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 65,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef MEM_STREAM_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       issue_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   ONE_LEFT = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr;
  // One bit wider than the address so a 256-beat burst fits.
  logic [ADDR_W:0]     remaining;
  logic                inflight;
  logic                inflight_last;

  logic [DATA_W-1:0]   fifo_data [DEPTH];
  logic [DEPTH-1:0]    fifo_last;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  logic cmd_fire, push, pop, credit_ok, final_issue, drained;

  assign cmd_fire    = cmd_valid && cmd_ready;
  // Returning data is always captured; credit checking at issue time makes this safe.
  assign push        = inflight;
  assign pop         = out_valid && out_ready;
  // The read about to be issued needs a slot beyond those already held or owed.
  assign credit_ok   = ({{PTR_W{1'b0}}, inflight} + count) < DEPTH_C;
  assign final_issue = mem_ren && (remaining == ONE_LEFT);
  // Leave DRAIN in the same cycle the last beat is popped so busy drops right after it.
  assign drained     = !inflight && ((count == '0) || ((count == CNT_ONE) && pop));

  assign mem_raddr = addr;
  assign out_valid = (count != '0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign busy      = (state != IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire)    state_next = ISSUE;
      ISSUE:   if (final_issue) state_next = DRAIN;
      DRAIN:   if (drained)     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // cmd_ready is masked by reset so it stays low during the reset cycle itself.
  always_comb begin
    cmd_ready = 1'b0;
    mem_ren   = 1'b0;
    case (state)
      IDLE:    cmd_ready = !reset;
      ISSUE:   mem_ren   = credit_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= mem_ren;
      inflight_last <= final_issue;
      if (cmd_fire) begin
        addr      <= cmd_base;
        remaining <= {1'b0, cmd_len} + ONE_LEFT;
      end else if (mem_ren) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ONE_LEFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; out_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  no_fifo_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (count == DEPTH_C)));

`ifdef MEM_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || cmd_fire) begin
      stall_cnt   <= '0;
      issue_stall <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if ((state == ISSUE) && !mem_ren && (issue_stall != 16'hFFFF))
        issue_stall <= issue_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
// tb_mem_read_streamer
//   Directed sequence of bursts against mem_read_streamer with a randomly
//   filled memory. Expected addresses, data and last flags are built from the
//   burst command alone (base + i modulo 256) and consumed in stream order.
module tb_mem_read_streamer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 65;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_len;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
`ifdef MEM_STREAM_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       issue_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem_model [256];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];
  logic              exp_last [$];

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_model[mem_raddr];
  end

  mem_read_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef MEM_STREAM_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .issue_stall (issue_stall)
`endif
  );

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cmd_ready", 96'(cmd_ready), 96'(0));
    checkOutput("reset_mem_ren",   96'(mem_ren),   96'(0));
    checkOutput("reset_mem_raddr", 96'(mem_raddr), 96'(0));
    checkOutput("reset_out_valid", 96'(out_valid), 96'(0));
    checkOutput("reset_out_last",  96'(out_last),  96'(0));
    checkOutput("reset_busy",      96'(busy),      96'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_cmd_ready", 96'(cmd_ready), 96'(1));
  endtask

  // Offers a command at a negedge and queues the expected beats for it.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
    int budget = 0;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("cmd_ready_idle", 96'(cmd_ready), 96'(1));
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    for (int i = 0; i <= int'(len); i++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem_model[a]);
      exp_last.push_back(i == int'(len));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_base  = ADDR_W'($urandom);
    cmd_len   = ADDR_W'($urandom);
    checkOutput("cmd_ready_in_burst", 96'(cmd_ready), 96'(0));
    checkOutput("busy_in_burst",      96'(busy),      96'(1));
  endtask

  // mode 0: out_ready always high; 1: low for the first 'hold' cycles; 2: random.
  // abort_after > 0 returns once that many beats have been accepted.
  task automatic streamBurst(input int mode, input int hold, input int abort_after);
    int k = 0;
    int issued = 0;
    int consumed = 0;
    int first_valid = -1;
    int total = exp_data.size();
    bit aborted = 1'b0;
    while (exp_data.size() != 0 && k < 3000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k >= hold);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (mem_ren) begin
        if (exp_addr.size() == 0) checkOutput("extra_read", 96'(1), 96'(0));
        else                      checkOutput("mem_raddr", 96'(mem_raddr), 96'(exp_addr.pop_front()));
        issued++;
        if (mode == 0) checkOutput("issue_back_to_back", 96'(k), 96'(issued - 1));
      end
      checkOutput("no_overflow", 96'((issued - consumed) <= DEPTH), 96'(1));
      if (out_valid && first_valid < 0) begin
        first_valid = k;
        checkOutput("first_valid_latency", 96'(k), 96'(2));
      end
      if (mode == 1 && k == hold - 1) begin
        checkOutput("credit_limited_reads", 96'(issued), 96'((total < DEPTH) ? total : DEPTH));
        checkOutput("held_mem_ren",  96'(mem_ren),   96'(0));
        checkOutput("held_out_valid", 96'(out_valid), 96'(1));
      end
      if (out_valid) begin
        checkOutput("out_data", 96'(out_data), 96'(exp_data[0]));
        checkOutput("out_last", 96'(out_last), 96'(exp_last[0]));
        if (out_ready) begin
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
          consumed++;
        end
      end
      if (abort_after > 0 && consumed == abort_after) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (k >= 3000) checkOutput("burst_timeout", 96'(exp_data.size()), 96'(0));
    if (!aborted) begin
      @(negedge clk);
      checkOutput("busy_after_last",   96'(busy),            96'(0));
      checkOutput("idle_out_valid",    96'(out_valid),       96'(0));
      checkOutput("idle_cmd_ready",    96'(cmd_ready),       96'(1));
      checkOutput("all_reads_issued",  96'(exp_addr.size()), 96'(0));
      checkOutput("beats_delivered",   96'(consumed),        96'(total));
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++)
      mem_model[i] = {1'($urandom), $urandom, $urandom};

    doReset();

    // Short aligned burst, consumer always ready.
    applyStimulus(8'h10, 8'd3);
    streamBurst(0, 0, 0);

    // Address wrap from FF to 00.
    applyStimulus(8'hFE, 8'd3);
    streamBurst(0, 0, 0);

    // Consumer stalled: reads stop at FIFO depth, head held stable.
    applyStimulus(8'h20, 8'd15);
    streamBurst(1, 10, 0);

    // Full 256-beat burst with random back-pressure.
    applyStimulus(8'($urandom), 8'd255);
    streamBurst(2, 0, 0);

    // Reset mid-burst after 5 beats, then a single-beat burst.
    applyStimulus(8'h80, 8'd15);
    streamBurst(0, 0, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 96'(out_valid), 96'(0));
    checkOutput("midreset_busy",      96'(busy),      96'(0));
    checkOutput("midreset_cmd_ready", 96'(cmd_ready), 96'(1));
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    applyStimulus(8'h40, 8'd0);
    streamBurst(0, 0, 0);

`ifdef MEM_STREAM_STATS_EN
    // Output held off for 7 cycles while valid.
    applyStimulus(8'h30, 8'd3);
    streamBurst(1, 9, 0);
    checkOutput("stall_cnt",   96'(stall_cnt),   96'(7));
    checkOutput("issue_stall", 96'(issue_stall), 96'(0));
    applyStimulus(8'h50, 8'd0);
    checkOutput("stall_cnt_cleared", 96'(stall_cnt), 96'(0));
    streamBurst(0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
